// File: rtl/simd_wave_controller_pkg.sv
// simd_wave_controller_pkg
// Shared definitions for the SIMD wave sequencer and its helpers:
//   - sequencer state encodings (SIMD_IDLE .. SIMD_DONE) and the enum built on them
//   - register-file writeback mux select constants (REG_WRITE_*)
//   - wave-cycle count / counter width derivation helpers and their default values
package simd_wave_controller_pkg;

   localparam logic [2:0] SIMD_IDLE    = 3'd0;
   localparam logic [2:0] SIMD_FETCH   = 3'd1;
   localparam logic [2:0] SIMD_DECODE  = 3'd2;
   localparam logic [2:0] SIMD_REQUEST = 3'd3;
   localparam logic [2:0] SIMD_WAIT    = 3'd4;
   localparam logic [2:0] SIMD_EXECUTE = 3'd5;
   localparam logic [2:0] SIMD_UPDATE  = 3'd6;
   localparam logic [2:0] SIMD_DONE    = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE    = SIMD_IDLE,
      ST_FETCH   = SIMD_FETCH,
      ST_DECODE  = SIMD_DECODE,
      ST_REQUEST = SIMD_REQUEST,
      ST_WAIT    = SIMD_WAIT,
      ST_EXECUTE = SIMD_EXECUTE,
      ST_UPDATE  = SIMD_UPDATE,
      ST_DONE    = SIMD_DONE
   } simd_state_e;

   // Writeback source selects used by the register files during EXECUTE.
   localparam logic [1:0] REG_WRITE_ALU   = 2'd0;
   localparam logic [1:0] REG_WRITE_MEM   = 2'd1;
   localparam logic [1:0] REG_WRITE_CONST = 2'd2;

   function automatic int calc_total_wave_cycles(input int wave_size, input int lane_width);
      return (wave_size + lane_width - 1) / lane_width;
   endfunction

   // A single-cycle wave still needs a 1-bit counter port.
   function automatic int calc_wc_w(input int total_wave_cycles);
      return (total_wave_cycles > 1) ? $clog2(total_wave_cycles) : 1;
   endfunction

   localparam int DEFAULT_TOTAL_WAVE_CYCLES = calc_total_wave_cycles(32, 16);
   localparam int DEFAULT_WC_W              = calc_wc_w(DEFAULT_TOTAL_WAVE_CYCLES);

endpackage

// File: rtl/simd_wave_controller_lane_mask.sv
// simd_lane_mask
// Combinational per-lane activity mask: a lane is active when the thread it
// carries in the current lane group falls below block_dim.
// Ports:
//   wave_id         in  32          wave index within the block
//   block_dim       in  32          threads per block
//   curr_wave_cycle in  WC_W        lane-group index within the wave
//   lane_active     out LANE_WIDTH  lane carries a live thread
// All arithmetic is 32-bit unsigned with products truncated to 32 bits.
module simd_lane_mask
   import simd_wave_controller_pkg::*;
#(
   parameter int LANE_WIDTH = 16,
   parameter int WAVE_SIZE  = 32,
   parameter int WC_W       = DEFAULT_WC_W
) (
   input  logic [31:0]           wave_id,
   input  logic [31:0]           block_dim,
   input  logic [WC_W-1:0]       curr_wave_cycle,
   output logic [LANE_WIDTH-1:0] lane_active
);

   logic [31:0] wave_base;
   logic [31:0] group_base;

   assign wave_base  = wave_id * 32'(WAVE_SIZE);
   assign group_base = wave_base + 32'(curr_wave_cycle) * 32'(LANE_WIDTH);

   for (genvar i = 0; i < LANE_WIDTH; i++) begin : g_lane
      assign lane_active[i] = (group_base + 32'(i)) < block_dim;
   end

endmodule

// File: rtl/simd_wave_controller.sv
// simd_wave_controller
// Sequencer for one SIMD unit. Steps a wavefront through fetch, decode, a
// request/wait/execute triple per lane group, then PC update, until RET
// retires the wave.
// Ports:
//   clk, rst (sync, active high), enable (freezes all state when low)
//   simd_start, wave_id, block_dim       wave dispatch
//   fetch_done, RET, MEM_READ, MEM_WRITE fetcher/decoder status
//   lsu_done                             per-lane LSU completion
//   simd_state, curr_wave_cycle, pc_out, simd_done  registered sequencer outputs
//   lane_active                          combinational lane mask
// Optional build macro SIMD_WAVE_CTRL_PERF_EN adds saturating counters
// instr_retired and stall_cycles.
//
// state   | meaning
// IDLE    | no wave, waiting for simd_start
// FETCH   | waiting for fetcher to present an instruction
// DECODE  | one cycle for the decoder
// REQUEST | LSUs launch transactions for the current lane group
// WAIT    | memory ops wait for all active lanes; others pass in one cycle
// EXECUTE | writeback for the lane group, advance or finish the wave cycle loop
// UPDATE  | RET retires the wave, otherwise PC advances
// DONE    | wave retired, simd_done held until next simd_start
module simd_wave_controller
   import simd_wave_controller_pkg::*;
#(
   parameter int  LANE_WIDTH             = 16,
   parameter int  WAVE_SIZE              = 32,
   parameter int  PROGRAM_MEM_ADDR_WIDTH = 6,
   localparam int TOTAL_WAVE_CYCLES      = calc_total_wave_cycles(WAVE_SIZE, LANE_WIDTH),
   localparam int WC_W                   = calc_wc_w(TOTAL_WAVE_CYCLES)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              simd_start,
   input  logic [31:0]                       wave_id,
   input  logic [31:0]                       block_dim,
   input  logic                              fetch_done,
   input  logic                              RET,
   input  logic                              MEM_READ,
   input  logic                              MEM_WRITE,
   input  logic [LANE_WIDTH-1:0]             lsu_done,
   output logic [2:0]                        simd_state,
   output logic [WC_W-1:0]                   curr_wave_cycle,
   output logic [LANE_WIDTH-1:0]             lane_active,
   output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_out,
`ifdef SIMD_WAVE_CTRL_PERF_EN
   output logic [31:0]                       instr_retired,
   output logic [31:0]                       stall_cycles,
`endif
   output logic                              simd_done
);

   localparam logic [WC_W-1:0] LAST_WC = WC_W'(TOTAL_WAVE_CYCLES - 1);

   simd_state_e state;
   logic        is_mem;
   logic        lanes_ready;
   logic        start_ok;

   simd_lane_mask #(
      .LANE_WIDTH (LANE_WIDTH),
      .WAVE_SIZE  (WAVE_SIZE),
      .WC_W       (WC_W)
   ) u_lane_mask (
      .wave_id         (wave_id),
      .block_dim       (block_dim),
      .curr_wave_cycle (curr_wave_cycle),
      .lane_active     (lane_active)
   );

   assign simd_state  = state;
   assign is_mem      = MEM_READ | MEM_WRITE;
   // Inactive lanes never issue, so they count as already complete; an
   // all-inactive group therefore leaves WAIT after one cycle.
   assign lanes_ready = &(lsu_done | ~lane_active);
   assign start_ok    = simd_start && (state == ST_IDLE || state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         pc_out          <= '0;
         curr_wave_cycle <= '0;
         simd_done       <= 1'b0;
      end else if (enable) begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (simd_start) begin
                  pc_out          <= '0;
                  curr_wave_cycle <= '0;
                  simd_done       <= 1'b0;
                  state           <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (fetch_done) state <= ST_DECODE;
            end
            ST_DECODE:  state <= ST_REQUEST;
            ST_REQUEST: state <= ST_WAIT;
            ST_WAIT: begin
               if (!is_mem || lanes_ready) state <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               if (curr_wave_cycle < LAST_WC) begin
                  curr_wave_cycle <= curr_wave_cycle + 1'b1;
                  state           <= ST_REQUEST;
               end else begin
                  curr_wave_cycle <= '0;
                  state           <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               if (RET) begin
                  simd_done <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  pc_out <= pc_out + 1'b1;
                  state  <= ST_FETCH;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef SIMD_WAVE_CTRL_PERF_EN
   // wait_seen marks that the previous enabled cycle was already WAIT, so
   // only the second and later WAIT cycles of a lane group count as stalls.
   logic wait_seen;

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_retired <= '0;
         stall_cycles  <= '0;
         wait_seen     <= 1'b0;
      end else if (enable) begin
         if (start_ok) begin
            instr_retired <= '0;
            stall_cycles  <= '0;
            wait_seen     <= 1'b0;
         end else begin
            if (state == ST_UPDATE && instr_retired != '1)
               instr_retired <= instr_retired + 1'b1;
            if (state == ST_WAIT && wait_seen && stall_cycles != '1)
               stall_cycles <= stall_cycles + 1'b1;
            wait_seen <= (state == ST_WAIT);
         end
      end
   end
`endif

endmodule

// File: tb/tb_simd_wave_controller.sv
// tb_simd_wave_controller
// Directed bench for simd_wave_controller: a table of per-cycle
// {inputs, expected outputs} records plus hand-written multi-cycle sequences
// (staggered LSU completion, reset mid-WAIT, PC wrap).
// Build with SIMD_WAVE_CTRL_PERF_EN defined to also check the perf counters.
module tb_simd_wave_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        simd_start;
   logic [31:0] wave_id;
   logic [31:0] block_dim;
   logic        fetch_done;
   logic        RET;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [15:0] lsu_done;
   logic [2:0]  simd_state;
   logic [0:0]  curr_wave_cycle;
   logic [15:0] lane_active;
   logic [5:0]  pc_out;
   logic        simd_done;
`ifdef SIMD_WAVE_CTRL_PERF_EN
   logic [31:0] instr_retired;
   logic [31:0] stall_cycles;
`endif

   int n_vec = 0;
   int n_err = 0;

   simd_wave_controller dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .simd_start      (simd_start),
      .wave_id         (wave_id),
      .block_dim       (block_dim),
      .fetch_done      (fetch_done),
      .RET             (RET),
      .MEM_READ        (MEM_READ),
      .MEM_WRITE       (MEM_WRITE),
      .lsu_done        (lsu_done),
      .simd_state      (simd_state),
      .curr_wave_cycle (curr_wave_cycle),
      .lane_active     (lane_active),
      .pc_out          (pc_out),
`ifdef SIMD_WAVE_CTRL_PERF_EN
      .instr_retired   (instr_retired),
      .stall_cycles    (stall_cycles),
`endif
      .simd_done       (simd_done)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        en, st, fd, ret, mr, mw;
      logic [15:0] lsu;
      logic [31:0] wid, bd;
      logic [2:0]  e_state;
      logic [0:0]  e_wc;
      logic [15:0] e_lane;
      logic [5:0]  e_pc;
      logic        e_done;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic en, st, fd, ret, mr, mw,
                               input logic [15:0] lsu, input logic [31:0] wid, bd,
                               input logic [2:0] e_state, input logic [0:0] e_wc,
                               input logic [15:0] e_lane, input logic [5:0] e_pc,
                               input logic e_done);
      vec_t v;
      v.en = en; v.st = st; v.fd = fd; v.ret = ret; v.mr = mr; v.mw = mw;
      v.lsu = lsu; v.wid = wid; v.bd = bd;
      v.e_state = e_state; v.e_wc = e_wc; v.e_lane = e_lane;
      v.e_pc = e_pc; v.e_done = e_done;
      vecs.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_row(input int idx, input vec_t v);
      n_vec++;
      if ({simd_state, curr_wave_cycle, lane_active, pc_out, simd_done} !==
          {v.e_state, v.e_wc, v.e_lane, v.e_pc, v.e_done}) begin
         n_err++;
         $display("FAIL row%0d: got st=%0d wc=%0d lane=%h pc=%0d done=%0d expected st=%0d wc=%0d lane=%h pc=%0d done=%0d",
                  idx, simd_state, curr_wave_cycle, lane_active, pc_out, simd_done,
                  v.e_state, v.e_wc, v.e_lane, v.e_pc, v.e_done);
      end
   endtask

   initial begin
      int waits;
      bit found;
      logic [5:0] exp_pc;

      rst = 1'b1; enable = 1'b1; simd_start = 1'b0; wave_id = 0; block_dim = 32;
      fetch_done = 1'b0; RET = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0; lsu_done = '0;

      //   en st fd rt mr mw lsu      wid bd   | st wc lane     pc d
      // ADD (non-memory, block_dim 32); simd_start during EXECUTE is ignored
      add(1, 1, 0, 0, 0, 0, 16'h0000, 0, 32,   0, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 0, 0, 0, 16'h0000, 0, 32,   1, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 0, 0, 0, 16'h0000, 0, 32,   2, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 0, 0, 0, 16'h0000, 0, 32,   3, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 0, 0, 0, 16'h0000, 0, 32,   4, 0, 16'hFFFF, 0, 0);
      add(1, 1, 1, 0, 0, 0, 16'h0000, 0, 32,   5, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 0, 0, 0, 16'h0000, 0, 32,   3, 1, 16'hFFFF, 0, 0);
      add(1, 0, 1, 0, 0, 0, 16'h0000, 0, 32,   4, 1, 16'hFFFF, 0, 0);
      add(1, 1, 1, 0, 0, 0, 16'h0000, 0, 32,   5, 1, 16'hFFFF, 0, 0);
      add(1, 0, 1, 0, 0, 0, 16'h0000, 0, 32,   6, 0, 16'hFFFF, 0, 0);
      // enable low for 5 cycles in FETCH, then RET instruction
      for (int k = 0; k < 5; k++)
         add(0, 0, 1, 1, 0, 0, 16'h0000, 0, 32, 1, 0, 16'hFFFF, 1, 0);
      add(1, 0, 1, 1, 0, 0, 16'h0000, 0, 32,   1, 0, 16'hFFFF, 1, 0);
      add(1, 0, 1, 1, 0, 0, 16'h0000, 0, 32,   2, 0, 16'hFFFF, 1, 0);
      add(1, 0, 1, 1, 0, 0, 16'h0000, 0, 32,   3, 0, 16'hFFFF, 1, 0);
      add(1, 0, 1, 1, 0, 0, 16'h0000, 0, 32,   4, 0, 16'hFFFF, 1, 0);
      add(1, 0, 1, 1, 0, 0, 16'h0000, 0, 32,   5, 0, 16'hFFFF, 1, 0);
      add(1, 0, 1, 1, 0, 0, 16'h0000, 0, 32,   3, 1, 16'hFFFF, 1, 0);
      add(1, 0, 1, 1, 0, 0, 16'h0000, 0, 32,   4, 1, 16'hFFFF, 1, 0);
      add(1, 0, 1, 1, 0, 0, 16'h0000, 0, 32,   5, 1, 16'hFFFF, 1, 0);
      add(1, 0, 1, 1, 0, 0, 16'h0000, 0, 32,   6, 0, 16'hFFFF, 1, 0);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 0, 32,   7, 0, 16'hFFFF, 1, 1);
      add(1, 0, 0, 0, 0, 0, 16'h0000, 0, 32,   7, 0, 16'hFFFF, 1, 1);
      // LOAD, block_dim 20, wave 0: partial second group, slow fetch
      add(1, 1, 0, 1, 1, 0, 16'h0000, 0, 20,   7, 0, 16'hFFFF, 1, 1);
      add(1, 0, 0, 1, 1, 0, 16'h0000, 0, 20,   1, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h0000, 0, 20,   1, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h0000, 0, 20,   2, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h0000, 0, 20,   3, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h0000, 0, 20,   4, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h7FFF, 0, 20,   4, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'hFFFF, 0, 20,   4, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h0000, 0, 20,   5, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h0000, 0, 20,   3, 1, 16'h000F, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h000F, 0, 20,   4, 1, 16'h000F, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h0000, 0, 20,   5, 1, 16'h000F, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h0000, 0, 20,   6, 0, 16'hFFFF, 0, 0);
      add(1, 0, 1, 1, 1, 0, 16'h0000, 0, 20,   7, 0, 16'hFFFF, 0, 1);
      // STORE, block_dim 20, wave 1: no active lanes, WAIT passes in one cycle
      add(1, 1, 1, 1, 0, 1, 16'h0000, 1, 20,   7, 0, 16'h0000, 0, 1);
      add(1, 0, 1, 1, 0, 1, 16'h0000, 1, 20,   1, 0, 16'h0000, 0, 0);
      add(1, 0, 1, 1, 0, 1, 16'h0000, 1, 20,   2, 0, 16'h0000, 0, 0);
      add(1, 0, 1, 1, 0, 1, 16'h0000, 1, 20,   3, 0, 16'h0000, 0, 0);
      add(1, 0, 1, 1, 0, 1, 16'h0000, 1, 20,   4, 0, 16'h0000, 0, 0);
      add(1, 0, 1, 1, 0, 1, 16'h0000, 1, 20,   5, 0, 16'h0000, 0, 0);
      add(1, 0, 1, 1, 0, 1, 16'h0000, 1, 20,   3, 1, 16'h0000, 0, 0);
      add(1, 0, 1, 1, 0, 1, 16'h0000, 1, 20,   4, 1, 16'h0000, 0, 0);
      add(1, 0, 1, 1, 0, 1, 16'h0000, 1, 20,   5, 1, 16'h0000, 0, 0);
      add(1, 0, 1, 1, 0, 1, 16'h0000, 1, 20,   6, 0, 16'h0000, 0, 0);
      add(1, 0, 1, 1, 0, 1, 16'h0000, 1, 20,   7, 0, 16'h0000, 0, 1);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vecs[k]) begin
         enable = vecs[k].en; simd_start = vecs[k].st; fetch_done = vecs[k].fd;
         RET = vecs[k].ret; MEM_READ = vecs[k].mr; MEM_WRITE = vecs[k].mw;
         lsu_done = vecs[k].lsu; wave_id = vecs[k].wid; block_dim = vecs[k].bd;
         @(negedge clk);
         check_row(k, vecs[k]);
         step();
      end

      // LOAD with lsu_done groups arriving 3 cycles apart in wave cycle 0
      enable = 1; wave_id = 0; block_dim = 32; RET = 0; MEM_READ = 1; MEM_WRITE = 0;
      fetch_done = 1; lsu_done = '0; simd_start = 1;
      step();
      simd_start = 0;
      @(negedge clk);
      check_val("stagger_fetch_state", 32'(simd_state), 32'd1);
`ifdef SIMD_WAVE_CTRL_PERF_EN
      check_val("perf_clear_instr", instr_retired, 32'd0);
      check_val("perf_clear_stall", stall_cycles, 32'd0);
`endif
      step(); step(); step();
      waits = 0;
      for (int c = 0; c < 20; c++) begin
         lsu_done = (waits < 3) ? 16'h003F : (waits < 6) ? 16'h07FF : 16'hFFFF;
         @(negedge clk);
         if (simd_state != 3'd4) break;
         waits++;
         step();
      end
      check_val("stagger_wait_cycles", 32'(waits), 32'd7);
      check_val("stagger_exit_state", 32'(simd_state), 32'd5);
      step();
      lsu_done = 16'hFFFF;
      step(); step(); step();
      @(negedge clk);
      check_val("stagger_update_state", 32'(simd_state), 32'd6);
`ifdef SIMD_WAVE_CTRL_PERF_EN
      check_val("perf_stall_cycles", stall_cycles, 32'd6);
`endif
      step();
      @(negedge clk);
      check_val("stagger_next_pc", 32'(pc_out), 32'd1);
`ifdef SIMD_WAVE_CTRL_PERF_EN
      check_val("perf_instr_retired", instr_retired, 32'd1);
`endif

      // Reset asserted mid-WAIT with lsu_done low
      lsu_done = '0;
      step(); step(); step(); step();
      @(negedge clk);
      check_val("wait_hold_state", 32'(simd_state), 32'd4);
      rst = 1;
      step();
      rst = 0;
      @(negedge clk);
      check_val("reset_mid_wait", {23'd0, simd_state, pc_out, simd_done}, 32'd0);

      // PC wrap: 64 non-RET instructions bring the PC from 0 back to 0
      MEM_READ = 0; fetch_done = 1; RET = 0; simd_start = 1;
      step();
      simd_start = 0;
      exp_pc = 6'd0;
      for (int n = 0; n < 64; n++) begin
         found = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (simd_state == 3'd6) begin
               found = 1;
               break;
            end
            step();
         end
         if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL wrap_timeout: got state %0d expected 6 within 20 cycles", simd_state);
            break;
         end
         check_val("wrap_update_pc", 32'(pc_out), 32'(exp_pc));
         exp_pc = exp_pc + 6'd1;
         step();
      end
      @(negedge clk);
      check_val("wrap_final_pc", 32'(pc_out), 32'd0);
      check_val("wrap_final_state", 32'(simd_state), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/simd_wave_controller.md
Name: simd_wave_controller

Overview:
- Sequencer for one SIMD unit: owns `simd_state`, the wavefront PC, the wave-cycle counter and the per-lane active mask.
- Steps one wavefront through fetch, decode, per-wave-cycle request/wait/execute, then PC update, until a RET instruction retires the wave.
- Sits beside the fetcher, decoder, register files and LSUs inside the SIMD unit; those blocks key their behaviour off `simd_state` and `curr_wave_cycle`.

Parameters:
- LANE_WIDTH, 16, number of ALU/LSU lanes.
- WAVE_SIZE, 32, threads per wavefront.
- PROGRAM_MEM_ADDR_WIDTH, 6, PC width.
- Derived localparam TOTAL_WAVE_CYCLES = ceil(WAVE_SIZE/LANE_WIDTH).
- Derived localparam WC_W = max(1, clog2(TOTAL_WAVE_CYCLES)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  advance when high; all state frozen when low
- simd_start  in  1  one-cycle pulse dispatching a new wave
- wave_id  in  32  wave index within block
- block_dim  in  32  threads per block
- fetch_done  in  1  fetcher holds a valid instruction
- RET  in  1  decoded instruction is return
- MEM_READ  in  1  decoded instruction loads
- MEM_WRITE  in  1  decoded instruction stores
- lsu_done  in  LANE_WIDTH  per-lane LSU transaction complete
- simd_state  out  3  current sequencer state
- curr_wave_cycle  out  WC_W  lane-group index within wave
- lane_active  out  LANE_WIDTH  lane maps to a thread below block_dim
- pc_out  out  PROGRAM_MEM_ADDR_WIDTH  wavefront PC
- simd_done  out  1  wave retired

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
- Reset values: simd_state=IDLE, pc_out=0, curr_wave_cycle=0, simd_done=0. lane_active is combinational from registered values.
- Reset takes effect mid-operation on the next edge; no partial-state retention.
- IDLE or DONE, on simd_start: pc_out←0, curr_wave_cycle←0, simd_done←0, go to FETCH.
- simd_start is ignored in all other states.
- FETCH: stay until fetch_done=1, then DECODE.
- DECODE: exactly one cycle, then REQUEST.
- REQUEST: one cycle, then WAIT. LSUs launch their transactions in this state.
- WAIT, memory instruction (MEM_READ|MEM_WRITE): stay until &(lsu_done | ~lane_active); exit in the cycle after the condition is seen.
- WAIT, non-memory instruction: exit after one cycle.
- WAIT, lane_active all zero: exit after one cycle.
- EXECUTE: one cycle; register-file writeback happens here.
  - If curr_wave_cycle < TOTAL_WAVE_CYCLES-1: curr_wave_cycle+1, go to REQUEST.
  - Else: curr_wave_cycle←0, go to UPDATE.
- UPDATE, RET=1: go to DONE; pc_out unchanged.
- UPDATE, RET=0: pc_out←pc_out+1 (modulo 2^PROGRAM_MEM_ADDR_WIDTH, so 63 wraps to 0), go to FETCH.
- DONE: simd_done=1 and held until the next accepted simd_start.
- lane_active[i] = (wave_id*WAVE_SIZE + curr_wave_cycle*LANE_WIDTH + i) < block_dim.
  - 32-bit unsigned arithmetic, products truncated to 32 bits.
- Minimum instruction latency, non-memory, 2 wave cycles, fetch_done immediate: FETCH 1 + DECODE 1 + 2×(3) + UPDATE 1 = 9 cycles.
- enable=0 overrides everything except rst.

Optional Feature:
- SIMD_WAVE_CTRL_PERF_EN: adds outputs instr_retired[31:0] and stall_cycles[31:0].
  - instr_retired increments on each UPDATE.
  - stall_cycles increments on each WAIT cycle beyond the first.
  - Both clear on rst and on accepted simd_start, and saturate at 0xFFFFFFFF.
- Without the macro: ports absent, no counters.

Decomposition:
- Shared package holds:
  - The state encodings, as localparams SIMD_IDLE through SIMD_DONE.
  - TOTAL_WAVE_CYCLES and WC_W derivation.
  - The REG_WRITE_* mux select constants, relocated alongside.
- One sub-module: simd_lane_mask. A purely combinational lane_active generator taking wave_id, block_dim and curr_wave_cycle.

Test Plan:
- Reset mid-WAIT with lsu_done=0 → next cycle simd_state=0, pc_out=0, simd_done=0.
- block_dim=32, wave_id=0, non-memory ADD then RET, fetch_done immediate → ADD takes 9 cycles; pc_out 0→1; simd_done rises after the RET instruction's UPDATE; lane_active=0xFFFF in both wave cycles.
- block_dim=20, wave_id=0 → lane_active=0xFFFF in cycle 0 and 0x000F in cycle 1. LOAD with only lanes 0–3 asserting lsu_done in cycle 1 → WAIT exits. block_dim=20, wave_id=1 → lane_active=0 in both cycles, WAIT exits after 1 cycle.
- LOAD with lsu_done lanes arriving 3 cycles apart → WAIT holds until the last lane; stall_cycles (PERF_EN) equals the observed extra cycles.
- simd_start pulsed during EXECUTE → ignored. pc_out at 63 with RET=0 → wraps to 0.
- enable low for 5 cycles in FETCH → simd_state and pc_out unchanged; resumes correctly when enable returns high.
